load_store_unit: RTL and testbench

- Sits between the datapath and the word-only data memory; the memory takes a word address, 32-bit write data and a write enable, and returns a 32-bit read word.
- Executes RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Does sign/zero extension of load data and read-modify-write merging for sub-word stores, because the memory only writes full words.
- Uses a small FSM with a req/ready/done handshake; alignment and encoding errors are flagged, never sent to memory.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the CPU-side request/response and the word-memory port of the load/store unit.
// Latency: none, wires only.
// Backpressure: ready gates req; the unit drives ready, the requester drives req.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // Unit side: takes requests and read data, drives responses and the memory port.
  modport slave (
    input  req, is_store, funct3, addr, wdata, mem_rd,
    output ready, done, err, rdata, mem_addr, mem_wd, mem_we
  );

  // Requester/memory side.
  modport master (
    output req, is_store, funct3, addr, wdata, mem_rd,
    input  ready, done, err, rdata, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: extends loads and does read-modify-write for SB/SH on a word-only memory.
// Latency: done in cycle 2 after acceptance for loads, SW and faults; cycle 3 for SB/SH.
// Backpressure: ready=1 only in IDLE; req while busy is dropped, not queued.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] FAULT  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_store_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] buf_q;

  logic              legal;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;
  logic              is_sw;

  // Legality of the incoming request: encoding first, then natural alignment.
  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      F_B:  legal = 1'b1;
      F_H:  legal = ~bus.addr[0];
      F_W:  legal = (bus.addr[1:0] == 2'b00);
      F_BU: legal = ~bus.is_store;
      F_HU: legal = ~bus.is_store & ~bus.addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: ld_byte = bus.mem_rd[7:0];
      2'd1: ld_byte = bus.mem_rd[15:8];
      2'd2: ld_byte = bus.mem_rd[23:16];
      default: ld_byte = bus.mem_rd[31:24];
    endcase
    ld_half  = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    load_val = '0;
    case (funct3_q)
      F_B:  load_val = {{24{ld_byte[7]}}, ld_byte};
      F_H:  load_val = {{16{ld_half[15]}}, ld_half};
      F_W:  load_val = bus.mem_rd;
      F_BU: load_val = {24'h000000, ld_byte};
      F_HU: load_val = {16'h0000, ld_half};
      default: load_val = '0;
    endcase
  end

  // Splice the store byte/half into the word captured during ACCESS.
  always_comb begin
    merged = buf_q;
    if (funct3_q == F_B) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  assign is_sw = is_store_q & (funct3_q == F_W);

  // Memory write port is a pure function of state and latched operands, so no input can glitch it.
  always_comb begin
    bus.mem_we = 1'b0;
    bus.mem_wd = '0;
    if (state == WRITE) begin
      bus.mem_we = 1'b1;
      bus.mem_wd = merged;
    end else if (state == ACCESS && is_sw) begin
      bus.mem_we = 1'b1;
      bus.mem_wd = wdata_q;
    end
  end

  assign bus.mem_addr = (state == IDLE) ? {bus.addr[ADDR_W-1:2], 2'b00}
                                        : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = (state == DONE) & err_q;
  assign bus.rdata    = rdata_q;

  // Access sequencer: latch operands on accept, then read, optionally write back, then report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      funct3_q   <= 3'd0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      buf_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q     <= bus.addr;
            funct3_q   <= bus.funct3;
            wdata_q    <= bus.wdata;
            is_store_q <= bus.is_store;
            err_q      <= ~legal;
            state      <= legal ? ACCESS : FAULT;
          end
        end
        ACCESS: begin
          if (!is_store_q) begin
            rdata_q <= load_val;
            state   <= DONE;
          end else if (funct3_q == F_W) begin
            state <= DONE;
          end else begin
            buf_q <= bus.mem_rd;
            state <= WRITE;
          end
        end
        WRITE:   state <= DONE;
        FAULT:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word behavioural memory.
// Latency: checks done cycle per access class.
// Backpressure: waits on ready before each request, bounded.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: synchronous write, combinational read; bench preloads through the same port.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end
  assign bus.mem_rd = mem[bus.mem_addr[9:2]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = a[9:2];
    pl_dat = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one request and observe it until done (bounded); reports what the bus showed.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output int done_cyc, output logic err_o,
                            output logic [31:0] rdata_o, output int we_cnt,
                            output logic [31:0] wd_o, output logic [31:0] acc_addr);
    int waited;
    done_cyc = 0; err_o = 1'b0; rdata_o = '0; we_cnt = 0; wd_o = '0; acc_addr = '0;
    waited = 0;
    @(negedge clk);
    while (!bus.ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    bus.req = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.is_store = ~st; bus.funct3 = 3'd7;
    bus.addr = 32'h0000_0303; bus.wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) acc_addr = bus.mem_addr;
      if (bus.mem_we) begin
        we_cnt++;
        wd_o = bus.mem_wd;
      end
      if (bus.done) begin
        done_cyc = k;
        err_o    = bus.err;
        rdata_o  = bus.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/done/err=%b%b%b required 100", bus.ready, bus.done, bus.err);
    end
    checks++;
    if (bus.rdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h mem_we=%b mem_wd=%h required 0/0/0",
               bus.rdata, bus.mem_we, bus.mem_wd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [31:0] ta [5];
    logic [2:0]  tf [5];
    logic [31:0] te [5];
    int dc, wc; logic e; logic [31:0] rd, wd, ma;
    ta = '{32'h101, 32'h102, 32'h103, 32'h102, 32'h100};
    tf = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd2};
    te = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01};
    preload(32'h100, 32'h80FF_7F01);
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, tf[i], ta[i], 32'h0, dc, e, rd, wc, wd, ma);
      checks++;
      if (rd !== te[i]) begin
        errors++;
        $display("FAIL load_data[%0d]: rdata=%h required %h", i, rd, te[i]);
      end
      checks++;
      if (dc !== 2 || e !== 1'b0 || wc !== 0 || ma !== 32'h100) begin
        errors++;
        $display("FAIL load_ctrl[%0d]: done_cycle=%0d err=%b we=%0d mem_addr=%h required 2/0/0/100",
                 i, dc, e, wc, ma);
      end
    end
  endtask

  task automatic test_sub_word_store();
    int dc, wc; logic e; logic [31:0] rd, wd, ma;
    preload(32'h200, 32'hAABB_CCDD);
    run_access(1'b1, 3'd0, 32'h202, 32'h1234_5678, dc, e, rd, wc, wd, ma);
    checks++;
    if (dc !== 3 || e !== 1'b0 || wc !== 1 || wd !== 32'hAA78_CCDD) begin
      errors++;
      $display("FAIL sb: done_cycle=%0d err=%b we=%0d mem_wd=%h required 3/0/1/aa78ccdd", dc, e, wc, wd);
    end
    checks++;
    if (mem[8'h80] !== 32'hAA78_CCDD) begin
      errors++;
      $display("FAIL sb_mem: word=%h required aa78ccdd", mem[8'h80]);
    end
    run_access(1'b1, 3'd1, 32'h202, 32'h0000_BEEF, dc, e, rd, wc, wd, ma);
    checks++;
    if (dc !== 3 || wc !== 1 || mem[8'h80] !== 32'hBEEF_CCDD) begin
      errors++;
      $display("FAIL sh: done_cycle=%0d we=%0d word=%h required 3/1/beefccdd", dc, wc, mem[8'h80]);
    end
    run_access(1'b0, 3'd2, 32'h200, 32'h0, dc, e, rd, wc, wd, ma);
    checks++;
    if (rd !== 32'hBEEF_CCDD || dc !== 2) begin
      errors++;
      $display("FAIL sh_readback: rdata=%h done_cycle=%0d required beefccdd/2", rd, dc);
    end
  endtask

  task automatic test_word_store();
    int dc, wc; logic e; logic [31:0] rd, wd, ma;
    preload(32'h204, 32'h1111_1111);
    run_access(1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, dc, e, rd, wc, wd, ma);
    checks++;
    if (dc !== 2 || wc !== 1 || wd !== 32'hCAFE_F00D || mem[8'h81] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL sw: done_cycle=%0d we=%0d mem_wd=%h word=%h required 2/1/cafef00d/cafef00d",
               dc, wc, wd, mem[8'h81]);
    end
    checks++;
    if (rd !== 32'hBEEF_CCDD) begin
      errors++;
      $display("FAIL sw_rdata_hold: rdata=%h required beefccdd", rd);
    end
  endtask

  task automatic test_faults();
    logic        fs [4];
    logic [2:0]  ff [4];
    logic [31:0] fa [4];
    int dc, wc; logic e; logic [31:0] rd, wd, ma;
    fs = '{1'b0, 1'b1, 1'b0, 1'b1};
    ff = '{3'd2, 3'd1, 3'd3, 3'd4};
    fa = '{32'h101, 32'h203, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_access(fs[i], ff[i], fa[i], 32'h5555_5555, dc, e, rd, wc, wd, ma);
      checks++;
      if (dc !== 2 || e !== 1'b1 || wc !== 0 || rd !== 32'hBEEF_CCDD) begin
        errors++;
        $display("FAIL fault[%0d]: done_cycle=%0d err=%b we=%0d rdata=%h required 2/1/0/beefccdd",
                 i, dc, e, wc, rd);
      end
    end
    checks++;
    if (mem[8'h40] !== 32'h80FF_7F01 || mem[8'h80] !== 32'hBEEF_CCDD) begin
      errors++;
      $display("FAIL fault_mem: w100=%h w200=%h required 80ff7f01/beefccdd", mem[8'h40], mem[8'h80]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [4];
    logic [31:0] exp_q [$];
    int accepts, dones;
    tbl = '{32'h100, 32'h104, 32'h108, 32'h10C};
    preload(32'h104, 32'h0102_0304);
    preload(32'h108, 32'h0506_0708);
    preload(32'h10C, 32'h090A_0B0C);
    accepts = 0; dones = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'd2; bus.wdata = 32'h0;
    for (int n = 0; n < 12; n++) begin
      bus.addr = tbl[n % 4];
      if (bus.done) begin
        dones++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_done: done with no accepted request at step %0d", n);
        end else begin
          if (bus.rdata !== mem[exp_q[0][9:2]]) begin
            errors++;
            $display("FAIL b2b_rdata[%0d]: rdata=%h required %h", n, bus.rdata, mem[exp_q[0][9:2]]);
          end
          void'(exp_q.pop_front());
        end
      end else if (!bus.ready && exp_q.size() != 0) begin
        checks++;
        if (bus.mem_addr !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_addr[%0d]: mem_addr=%h required %h", n, bus.mem_addr, exp_q[0]);
        end
      end
      if (bus.ready) begin
        exp_q.push_back(tbl[n % 4]);
        accepts++;
      end
      @(negedge clk);
    end
    bus.req = 1'b0;
    checks++;
    if (accepts !== 4 || dones !== 4) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d dones=%0d required 4/4", accepts, dones);
    end
  endtask

  task automatic test_reset_mid_write();
    int waited;
    preload(32'h300, 32'h1122_3344);
    waited = 0;
    @(negedge clk);
    while (!bus.ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'h300; bus.wdata = 32'h55;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: mem_we=%b required 1 in write state", bus.mem_we);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.ready !== 1'b1 || bus.rdata !== 32'h0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: mem_we=%b ready=%b rdata=%h done=%b required 0/1/0/0",
               bus.mem_we, bus.ready, bus.rdata, bus.done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[8'hC0] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL rst_mem: word=%h required 11223344", mem[8'hC0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_word_store();
    test_faults();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
